// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: state encodings, register address width
// and the source/destination dependency test used by the load-use detector.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    localparam logic [1:0] HZ_RUN       = 2'd0;
    localparam logic [1:0] HZ_LOAD_USE  = 2'd1;
    localparam logic [1:0] HZ_CSR_DRAIN = 2'd2;
    localparam logic [1:0] HZ_MEM_WAIT  = 2'd3;

    // A source only depends on a destination when it is actually read and is not x0.
    function automatic logic reg_dep(input logic                  used,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
        return used && (src == dst) && (dst != X0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use detector: the ID instruction reads the register a load in EX
// is about to write, which bypass cannot supply in time.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    output logic                  o_load_use
);

    assign o_load_use = i_id_valid && i_ex_valid && i_ex_is_load &&
                        (reg_dep(i_id_use_rs1, i_id_rs1, i_ex_rd) ||
                         reg_dep(i_id_use_rs2, i_id_rs2, i_ex_rd));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, CSR serialization, data-memory wait
// states with timeout, and redirect flushes for the IF/ID/EX stage registers.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic                  i_id_is_csr,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_mem_valid,
    input  logic                  i_wb_valid,
    input  logic                  i_redirect,
    input  logic                  i_dmem_req,
    input  logic                  i_dmem_ack,
    output logic                  o_stall_if,
    output logic                  o_stall_id,
    output logic                  o_stall_ex,
    output logic                  o_bubble_ex,
    output logic                  o_flush_id,
    output logic                  o_flush_ex,
    output logic                  o_mem_timeout,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q;

    logic load_use, pipe_busy;
    logic stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex;

    hazard_detect u_detect (
        .i_id_valid   (i_id_valid),
        .i_id_rs1     (i_id_rs1),
        .i_id_rs2     (i_id_rs2),
        .i_id_use_rs1 (i_id_use_rs1),
        .i_id_use_rs2 (i_id_use_rs2),
        .i_ex_valid   (i_ex_valid),
        .i_ex_is_load (i_ex_is_load),
        .i_ex_rd      (i_ex_rd),
        .o_load_use   (load_use)
    );

    assign pipe_busy = i_ex_valid || i_mem_valid || i_wb_valid;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        tmo_d     = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        case (state_q)
            HZ_RUN, HZ_LOAD_USE, HZ_CSR_DRAIN: begin
                // LOAD_USE is the cycle the bubble occupies EX, so load-use is not re-detected.
                if (i_redirect) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    state_d  = HZ_RUN;
                end else if (i_dmem_req && !i_dmem_ack) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    wait_d   = '0;
                    state_d  = HZ_MEM_WAIT;
                end else if (state_q == HZ_RUN && load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = HZ_LOAD_USE;
                end else if ((state_q == HZ_CSR_DRAIN || i_id_is_csr) && pipe_busy) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = HZ_CSR_DRAIN;
                end else begin
                    state_d = HZ_RUN;
                end
            end
            default: begin
                // Memory wait: EX is frozen, so redirects wait until we are back in RUN.
                if (i_dmem_ack) begin
                    state_d = HZ_RUN;
                end else if (wait_q == TMO_LAST) begin
                    flush_ex = 1'b1;
                    tmo_d    = 1'b1;
                    state_d  = HZ_RUN;
                end else begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    wait_d   = wait_q + TMO_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HZ_RUN;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_q + CNT_W'(stall_if);
        end
    end

    assign o_stall_if    = stall_if  && !i_rst;
    assign o_stall_id    = stall_id  && !i_rst;
    assign o_stall_ex    = stall_ex  && !i_rst;
    assign o_bubble_ex   = bubble_ex && !i_rst;
    assign o_flush_id    = flush_id  && !i_rst;
    assign o_flush_ex    = flush_ex  && !i_rst;
    assign o_mem_timeout = tmo_q;
    assign o_stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by randomized traffic, all checked
// against a rule-level reference model of the stall/flush behaviour.
module tb_hazard_ctrl;

    localparam int TMO = 8;
    localparam int CW  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, use_rs1, use_rs2, id_is_csr;
    logic [4:0] rs1, rs2, ex_rd;
    logic       ex_valid, ex_is_load, mem_valid, wb_valid;
    logic       redirect, dmem_req, dmem_ack;

    logic          stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex, mem_timeout;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_use_rs1(use_rs1), .i_id_use_rs2(use_rs2), .i_id_is_csr(id_is_csr),
        .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
        .i_mem_valid(mem_valid), .i_wb_valid(wb_valid), .i_redirect(redirect),
        .i_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
        .o_stall_if(stall_if), .o_stall_id(stall_id), .o_stall_ex(stall_ex),
        .o_bubble_ex(bubble_ex), .o_flush_id(flush_id), .o_flush_ex(flush_ex),
        .o_mem_timeout(mem_timeout), .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: what the pipe is currently doing, described by the spec's rules.
    bit m_bubble_in_ex, m_draining, m_waiting, m_tmo_out;
    int m_wait_done, m_stalls;
    bit n_bubble_in_ex, n_draining, n_waiting, n_tmo_out, e_stall;
    int n_wait_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval(output logic [6:0] flags);
        bit pipe, lu, si, sid, sex, bub, fid, fex;
        pipe = ex_valid | mem_valid | wb_valid;
        lu = id_valid && ex_valid && ex_is_load && ex_rd != 5'd0 &&
             ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
        {si, sid, sex, bub, fid, fex} = '0;
        n_bubble_in_ex = 0; n_draining = 0; n_waiting = 0; n_wait_done = 0; n_tmo_out = 0;
        if (m_waiting) begin
            if (dmem_ack) begin
            end else if (m_wait_done + 1 == TMO) begin
                fex = 1; n_tmo_out = 1;
            end else begin
                si = 1; sid = 1; sex = 1; n_waiting = 1; n_wait_done = m_wait_done + 1;
            end
        end else if (redirect) begin
            fid = 1; fex = 1;
        end else if (dmem_req && !dmem_ack) begin
            si = 1; sid = 1; sex = 1; n_waiting = 1; n_wait_done = 0;
        end else if (lu && !m_bubble_in_ex && !m_draining) begin
            si = 1; sid = 1; bub = 1; n_bubble_in_ex = 1;
        end else if ((id_is_csr || m_draining) && pipe) begin
            si = 1; sid = 1; bub = 1; n_draining = 1;
        end
        if (rst) {si, sid, sex, bub, fid, fex} = '0;
        e_stall = si;
        flags = {si, sid, sex, bub, fid, fex, m_tmo_out};
    endtask

    task automatic model_commit();
        if (rst) begin
            m_bubble_in_ex = 0; m_draining = 0; m_waiting = 0;
            m_wait_done = 0; m_tmo_out = 0; m_stalls = 0;
        end else begin
            m_bubble_in_ex = n_bubble_in_ex; m_draining = n_draining;
            m_waiting = n_waiting; m_wait_done = n_wait_done; m_tmo_out = n_tmo_out;
            m_stalls = (m_stalls + int'(e_stall)) % (1 << CW);
        end
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1 ns later.
    task automatic cycle(input string tag);
        logic [6:0] exp;
        #1;
        model_eval(exp);
        chk({tag, "_flags"},
            {25'd0, stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex, mem_timeout},
            {25'd0, exp});
        chk({tag, "_cnt"}, 32'(stall_cnt), 32'(m_stalls));
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0; id_is_csr = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; mem_valid = 0; wb_valid = 0;
        redirect = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic set_load_use();
        id_valid = 1; rs1 = 5'd5; use_rs1 = 1; rs2 = 5'd1; use_rs2 = 1;
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5;
    endtask

    task automatic rand_inputs();
        id_valid   = $urandom_range(0, 3) != 0;
        rs1        = 5'($urandom_range(0, 3));
        rs2        = 5'($urandom_range(0, 3));
        use_rs1    = $urandom_range(0, 1) != 0;
        use_rs2    = $urandom_range(0, 1) != 0;
        id_is_csr  = $urandom_range(0, 7) == 0;
        ex_valid   = $urandom_range(0, 2) != 0;
        ex_is_load = $urandom_range(0, 2) == 0;
        ex_rd      = 5'($urandom_range(0, 3));
        mem_valid  = $urandom_range(0, 1) != 0;
        wb_valid   = $urandom_range(0, 1) != 0;
        redirect   = $urandom_range(0, 15) == 0;
        dmem_req   = $urandom_range(0, 3) == 0;
        dmem_ack   = $urandom_range(0, 3) == 0;
        rst        = $urandom_range(0, 249) == 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        m_bubble_in_ex = 0; m_draining = 0; m_waiting = 0;
        m_wait_done = 0; m_tmo_out = 0; m_stalls = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle("reset");
        rst = 0;
        chk("reset_cnt", 32'(stall_cnt), 32'd0);

        // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then the load moves to MEM.
        set_load_use();
        cycle("lu_detect");
        ex_valid = 0; ex_is_load = 0; mem_valid = 1;
        cycle("lu_bubble");
        idle_inputs();
        cycle("lu_run");
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // x0 destination and an unused rs2 never stall.
        id_valid = 1; rs1 = 0; use_rs1 = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 0;
        #1 chk("x0_stall", 32'(stall_if), 32'd0);
        cycle("x0");
        rs1 = 5'd2; rs2 = 5'd5; use_rs2 = 0; ex_rd = 5'd5;
        #1 chk("unused_rs2_stall", 32'(stall_if), 32'd0);
        cycle("unused_rs2");
        idle_inputs();
        cycle("idle0");
        chk("no_stall_cnt", 32'(stall_cnt), 32'd1);

        // csrrw in ID while EX/MEM/WB drain one stage per cycle.
        id_valid = 1; id_is_csr = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
        cycle("csr_d1");
        ex_valid = 0;
        cycle("csr_d2");
        mem_valid = 0;
        cycle("csr_d3");
        wb_valid = 0;
        #1 chk("csr_issue_stall", 32'(stall_if), 32'd0);
        cycle("csr_issue");
        idle_inputs();
        chk("csr_cnt", 32'(stall_cnt), 32'd4);

        // Data access acknowledged after 4 cycles; a redirect during the wait is ignored.
        mem_valid = 1; dmem_req = 1;
        cycle("mw_0");
        cycle("mw_1");
        redirect = 1;
        #1 chk("mw_redirect_ignored", 32'(flush_id), 32'd0);
        cycle("mw_2");
        redirect = 0;
        cycle("mw_3");
        dmem_ack = 1;
        #1 chk("mw_ack_stall_ex", 32'(stall_ex), 32'd0);
        cycle("mw_ack");
        idle_inputs();
        chk("mw_cnt", 32'(stall_cnt), 32'd8);

        // Never acknowledged: timeout after TMO wait cycles, flush EX, pulse one cycle later.
        mem_valid = 1; dmem_req = 1;
        for (int i = 0; i < TMO; i++) cycle("tmo_wait");
        #1 chk("tmo_flush_ex", 32'(flush_ex), 32'd1);
        cycle("tmo_fire");
        idle_inputs();
        chk("tmo_pulse", 32'(mem_timeout), 32'd1);
        cycle("tmo_after");
        chk("tmo_pulse_end", 32'(mem_timeout), 32'd0);
        chk("tmo_cnt", 32'(stall_cnt), 32'd16);

        // Redirect together with a load-use hazard: flush only.
        set_load_use();
        redirect = 1;
        #1 chk("redir_lu", {30'd0, flush_id, flush_ex}, 32'd3);
        chk("redir_lu_stall", 32'(stall_if), 32'd0);
        cycle("redir_lu");
        idle_inputs();
        cycle("idle1");

        // Reset while draining for a CSR.
        id_valid = 1; id_is_csr = 1; ex_valid = 1; wb_valid = 1;
        cycle("rd_d1");
        cycle("rd_d2");
        rst = 1;
        cycle("rd_rst");
        rst = 0;
        idle_inputs();
        #1 chk("rd_after_stall", 32'(stall_if), 32'd0);
        chk("rd_after_cnt", 32'(stall_cnt), 32'd0);
        cycle("rd_after");

        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            cycle("rand");
        end
        rst = 0;
        idle_inputs();
        cycle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
